// File: rtl/cluster_clock_monitor.sv
// rtl/cluster_clock_monitor.sv - period and stall monitor for an asynchronous cluster clock
// Measures mon_clk_i in clk_i cycles; sticky timeout_o when no edge is seen for TIMEOUT cycles.
module cluster_clock_monitor #(
   parameter int CNT_WIDTH = 16,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 clear_i,
   input  logic                 mon_clk_i,
   output logic [CNT_WIDTH-1:0] period_o,
   output logic                 period_valid_o,
   output logic                 alive_o,
   output logic                 timeout_o
);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

   state_t               state;
   state_t               state_n;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_n;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [CNT_WIDTH-1:0] period_n;
   logic                 s1;
   logic                 s2;
   logic                 s3;
   logic                 rise;
   logic                 tmo_hit;
   logic                 valid_n;
   logic                 alive_n;
   logic                 timeout_n;

   // mon_clk_i is treated purely as data; s1/s2 resolve metastability, s3 finds the edge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= mon_clk_i;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise    = s2 & ~s3;
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
   // cnt restarts at 1 after an edge and at 0 on entering ARM, so one compare serves both
   assign tmo_hit = (cnt == TO_LAST) & ~rise;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      period_n  = period_o;
      valid_n   = 1'b0;
      alive_n   = alive_o;
      timeout_n = timeout_o;
      if (clear_i) begin
         timeout_n = 1'b0;
      end
      if (!en_i) begin
         state_n = IDLE;
         cnt_n   = '0;
         alive_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state_n = ARM;
               cnt_n   = '0;
            end
            ARM: begin
               if (rise) begin
                  state_n = MEASURE;
                  cnt_n   = CNT_ONE;
               end else if (tmo_hit) begin
                  timeout_n = 1'b1;
                  alive_n   = 1'b0;
                  cnt_n     = '0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period_n = cnt;
                  valid_n  = 1'b1;
                  alive_n  = 1'b1;
                  cnt_n    = CNT_ONE;
               end else if (tmo_hit) begin
                  timeout_n = 1'b1;
                  alive_n   = 1'b0;
                  state_n   = ARM;
                  cnt_n     = '0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         cnt            <= '0;
         period_o       <= '0;
         period_valid_o <= 1'b0;
         alive_o        <= 1'b0;
         timeout_o      <= 1'b0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         period_o       <= period_n;
         period_valid_o <= valid_n;
         alive_o        <= alive_n;
         timeout_o      <= timeout_n;
      end
   end

endmodule

// File: tb/tb_cluster_clock_monitor.sv
// tb/tb_cluster_clock_monitor.sv - self-checking bench for cluster_clock_monitor
// Event-timestamp reference model compared every cycle, plus directed literal checks.
module tb_cluster_clock_monitor;

   localparam int W  = 16;
   localparam int TO = 32;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         en    = 1'b0;
   logic         clear = 1'b0;
   logic         mon   = 1'b0;
   logic [W-1:0] period;
   logic         period_valid;
   logic         alive;
   logic         timeout;

   cluster_clock_monitor #(.CNT_WIDTH(W), .TIMEOUT(TO)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .en_i           (en),
      .clear_i        (clear),
      .mon_clk_i      (mon),
      .period_o       (period),
      .period_valid_o (period_valid),
      .alive_o        (alive),
      .timeout_o      (timeout)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int pulses = 0;

   // monitored-clock generator: 0 = hold gen_level, 1 = square wave hi/lo, 2 = random bits
   int gen_mode  = 0;
   bit gen_level = 1'b0;
   int hi = 4;
   int lo = 4;
   int ph = 0;

   // reference model: timestamps of edges rather than counters
   int           m_edge     = 0;
   int           m_mode     = 0;   // 0 idle, 1 armed, 2 measuring
   int           m_last     = 0;
   int           m_deadline = 0;
   logic [W-1:0] m_period   = '0;
   bit           m_valid    = 1'b0;
   bit           m_alive    = 1'b0;
   bit           m_tmo      = 1'b0;
   bit           m_live     = 1'b0;
   bit           samp[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_step();
      bit r;
      bit tev;
      int p;
      int sz;
      m_edge++;
      sz  = samp.size();
      r   = samp[sz-2] && !samp[sz-3];
      samp.push_back(mon);
      if (samp.size() > 8) void'(samp.pop_front());
      m_valid = 1'b0;
      tev     = 1'b0;
      if (rst) begin
         sz = samp.size();
         samp[sz-1] = 1'b0;
         samp[sz-2] = 1'b0;
         samp[sz-3] = 1'b0;
         m_mode   = 0;
         m_period = '0;
         m_alive  = 1'b0;
         m_tmo    = 1'b0;
         m_live   = 1'b1;
      end else begin
         if (!en) begin
            m_mode  = 0;
            m_alive = 1'b0;
         end else if (m_mode == 0) begin
            m_mode     = 1;
            m_deadline = m_edge + TO;
         end else if (r) begin
            if (m_mode == 2) begin
               p        = m_edge - m_last;
               m_period = (p > 65535) ? 16'hffff : W'(p);
               m_valid  = 1'b1;
               m_alive  = 1'b1;
            end
            m_mode     = 2;
            m_last     = m_edge;
            m_deadline = m_edge + TO - 1;
         end else if (m_edge == m_deadline) begin
            tev        = 1'b1;
            m_tmo      = 1'b1;
            m_alive    = 1'b0;
            m_mode     = 1;
            m_deadline = m_edge + TO;
         end
         if (clear && !tev) m_tmo = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (m_live) begin
         chk("period_o", 32'(period), 32'(m_period));
         chk("period_valid_o", 32'(period_valid), 32'(m_valid));
         chk("alive_o", 32'(alive), 32'(m_alive));
         chk("timeout_o", 32'(timeout), 32'(m_tmo));
      end
      if (period_valid === 1'b1) pulses++;
      model_step();
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (gen_mode)
         0: mon = gen_level;
         1: begin
            if (ph <= 1) begin
               mon = ~mon;
               ph  = mon ? hi : lo;
            end else begin
               ph--;
            end
         end
         default: mon = 1'($urandom_range(0, 1));
      endcase
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
      $fatal(1);
   end

   initial begin
      int p0;
      bit found;
      repeat (3) samp.push_back(1'b0);

      rst = 1'b1;
      step(3);
      @(negedge clk);
      chk("reset_period", 32'(period), 0);
      chk("reset_valid", 32'(period_valid), 0);
      chk("reset_alive", 32'(alive), 0);
      chk("reset_timeout", 32'(timeout), 0);
      step(1);
      rst = 1'b0;
      en  = 1'b1;
      hi = 4; lo = 4; gen_mode = 1;

      step(100);
      @(negedge clk);
      chk("div8_period", 32'(period), 8);
      chk("div8_alive", 32'(alive), 1);
      chk("div8_timeout", 32'(timeout), 0);
      step(1);
      p0 = pulses;
      step(80);
      chk("div8_pulses", 32'(pulses - p0), 10);

      gen_level = 1'b0; gen_mode = 0;
      step(60);
      @(negedge clk);
      chk("stall_timeout", 32'(timeout), 1);
      chk("stall_alive", 32'(alive), 0);
      chk("stall_period_hold", 32'(period), 8);

      step(1);
      hi = 4; lo = 4; gen_mode = 1;
      step(40);
      @(negedge clk);
      chk("restart_alive", 32'(alive), 1);
      chk("restart_sticky", 32'(timeout), 1);
      chk("restart_period", 32'(period), 8);
      step(1);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      @(negedge clk);
      chk("clear_timeout", 32'(timeout), 0);

      step(1);
      hi = 1; lo = 1;
      step(40);
      @(negedge clk);
      chk("div2_period", 32'(period), 2);
      step(1);
      p0 = pulses;
      step(40);
      chk("div2_pulses", 32'(pulses - p0), 20);
      hi = 2; lo = 3;
      step(40);
      @(negedge clk);
      chk("div5_period", 32'(period), 5);

      step(1);
      en = 1'b0;
      step(3);
      p0 = pulses;
      step(30);
      chk("en_off_pulses", 32'(pulses - p0), 0);
      @(negedge clk);
      chk("en_off_alive", 32'(alive), 0);
      chk("en_off_period", 32'(period), 5);
      step(1);
      en = 1'b1; hi = 4; lo = 4;
      step(40);
      @(negedge clk);
      chk("reenable_period", 32'(period), 8);

      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      chk("midreset_period", 32'(period), 0);
      chk("midreset_alive", 32'(alive), 0);
      chk("midreset_timeout", 32'(timeout), 0);
      step(40);
      @(negedge clk);
      chk("after_reset_period", 32'(period), 8);

      // clear_i in the same cycle the timeout fires: timeout must win
      step(1);
      gen_level = 1'b0; gen_mode = 0;
      step(4);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_mode != 0 && m_deadline == m_edge + 1 && mon == 1'b0) begin
            clear = 1'b1;
            step(1);
            clear = 1'b0;
            found = 1'b1;
         end else begin
            step(1);
         end
      end
      chk("coincide_found", 32'(found), 1);
      @(negedge clk);
      chk("coincide_timeout_wins", 32'(timeout), 1);
      step(1);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      @(negedge clk);
      chk("late_clear", 32'(timeout), 0);
      step(1);

      for (int it = 0; it < 40; it++) begin
         int sel;
         int len;
         sel = $urandom_range(0, 9);
         gen_mode  = (sel < 2) ? 0 : (sel < 8) ? 1 : 2;
         gen_level = 1'($urandom_range(0, 1));
         hi = $urandom_range(1, 20);
         lo = $urandom_range(1, 20);
         en = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 19) == 0);
         step(1);
         rst = 1'b0;
         len = $urandom_range(30, 150);
         for (int c = 0; c < len; c++) begin
            clear = ($urandom_range(0, 15) == 0);
            step(1);
         end
         clear = 1'b0;
      end

      step(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
